// File: rtl/smg_scan_control_if.sv
// Bus bundle between the display scheduler and its host: scan control, display data
// load handshake, and the per-slot digit/select outputs.
interface smg_scan_control_if;
    logic        En;
    logic [23:0] Disp_Data;
    logic        Load_Req;
    logic        Lz_En;
    logic [3:0]  Number_Data;
    logic [5:0]  rScan;
    logic        Load_Ack;
    logic        Frame_Done;

    modport master (
        output En,
        output Disp_Data,
        output Load_Req,
        output Lz_En,
        input  Number_Data,
        input  rScan,
        input  Load_Ack,
        input  Frame_Done
    );

    modport slave (
        input  En,
        input  Disp_Data,
        input  Load_Req,
        input  Lz_En,
        output Number_Data,
        output rScan,
        output Load_Ack,
        output Frame_Done
    );
endinterface

// File: rtl/smg_scan_control.sv
// Six-digit seven-segment scan scheduler: rotates an active-low digit select at a
// programmable slot rate, with a double-buffered display value and leading-zero blanking.
module smg_scan_control #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          LZ_DEFAULT = 1'b1
) (
    input logic                CLK,
    input logic                RST,
    smg_scan_control_if.slave  bus
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      idx_nxt;
    logic            tick, wrap;

    logic [23:0]     pend_buf_q, pend_buf_d;
    logic            pend_valid_q, pend_valid_d;
    logic [23:0]     active_buf_q, active_buf_d;
    logic            lz_q;

    logic [5:0]      rscan_q, rscan_d;
    logic [3:0]      number_q, number_d;
    logic            load_ack_q, load_ack_d;
    logic            frame_done_q, frame_done_d;

    logic [3:0]      digit_raw;
    logic [5:0]      upper_zero;
    logic            upper_zero_sel;
    logic            blank;

    // Slot divider and digit index; both freeze while scanning is disabled.
    always_comb begin
        tick      = bus.En && (div_cnt_q == DivLast);
        wrap      = tick && (idx_q == 3'd5);
        idx_nxt   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        div_cnt_d = div_cnt_q;
        if (bus.En) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end
        idx_d = tick ? idx_nxt : idx_q;
    end

    // Double buffer: a pending value only becomes active on the frame wrap.
    always_comb begin
        pend_buf_d   = pend_buf_q;
        pend_valid_d = pend_valid_q;
        active_buf_d = active_buf_q;
        load_ack_d   = 1'b0;
        if (wrap) begin
            if (bus.Load_Req) begin
                active_buf_d = bus.Disp_Data;
                pend_valid_d = 1'b0;
                load_ack_d   = 1'b1;
            end else if (pend_valid_q) begin
                active_buf_d = pend_buf_q;
                pend_valid_d = 1'b0;
                load_ack_d   = 1'b1;
            end
        end else if (bus.Load_Req) begin
            pend_buf_d   = bus.Disp_Data;
            pend_valid_d = 1'b1;
        end
    end

    // upper_zero[k]: digits k..5 of the buffer being displayed next are all zero.
    always_comb begin
        upper_zero[5] = (active_buf_d[23:20] == 4'd0);
        upper_zero[4] = upper_zero[5] && (active_buf_d[19:16] == 4'd0);
        upper_zero[3] = upper_zero[4] && (active_buf_d[15:12] == 4'd0);
        upper_zero[2] = upper_zero[3] && (active_buf_d[11:8] == 4'd0);
        upper_zero[1] = upper_zero[2] && (active_buf_d[7:4] == 4'd0);
        upper_zero[0] = upper_zero[1] && (active_buf_d[3:0] == 4'd0);
    end

    always_comb begin
        unique case (idx_nxt)
            3'd0:    begin digit_raw = active_buf_d[3:0];   upper_zero_sel = upper_zero[0]; end
            3'd1:    begin digit_raw = active_buf_d[7:4];   upper_zero_sel = upper_zero[1]; end
            3'd2:    begin digit_raw = active_buf_d[11:8];  upper_zero_sel = upper_zero[2]; end
            3'd3:    begin digit_raw = active_buf_d[15:12]; upper_zero_sel = upper_zero[3]; end
            3'd4:    begin digit_raw = active_buf_d[19:16]; upper_zero_sel = upper_zero[4]; end
            3'd5:    begin digit_raw = active_buf_d[23:20]; upper_zero_sel = upper_zero[5]; end
            default: begin digit_raw = active_buf_d[3:0];   upper_zero_sel = upper_zero[0]; end
        endcase
    end

    // Digit 0 is never blanked so an all-zero value still shows a single "0".
    always_comb begin
        blank        = lz_q && (idx_nxt != 3'd0) && upper_zero_sel;
        rscan_d      = rscan_q;
        number_d     = number_q;
        frame_done_d = wrap;
        if (!bus.En) begin
            rscan_d = 6'b111111;
        end else if (tick) begin
            number_d = (digit_raw > 4'd9) ? 4'd10 : digit_raw;
            rscan_d  = blank ? 6'b111111 : ~(6'b000001 << idx_nxt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_q    <= '0;
            idx_q        <= 3'd0;
            pend_buf_q   <= 24'd0;
            pend_valid_q <= 1'b0;
            active_buf_q <= 24'd0;
            lz_q         <= LZ_DEFAULT;
            rscan_q      <= 6'b111111;
            number_q     <= 4'd0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pend_buf_q   <= pend_buf_d;
            pend_valid_q <= pend_valid_d;
            active_buf_q <= active_buf_d;
            lz_q         <= bus.Lz_En;
            rscan_q      <= rscan_d;
            number_q     <= number_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rScan       = rscan_q;
    assign bus.Number_Data = number_q;
    assign bus.Load_Ack    = load_ack_q;
    assign bus.Frame_Done  = frame_done_q;

endmodule

// File: doc/smg_scan_control.md
Name: smg_scan_control

Overview:
Time-multiplexing scheduler for the 6-digit common-anode seven-segment display. It cycles one active-low digit select across the six digits at a programmable rate. For the selected digit it presents the 4-bit digit code to smg_encode_module, together with the 6-bit active-low scan vector that smg_encode_module uses for decimal-point insertion. Display data is double-buffered so a new value is applied only at a frame boundary, which prevents tearing.

Parameters:
SCAN_DIV, 50000, CLK cycles per digit slot (1 ms at 50 MHz); legal range >= 2.
LZ_DEFAULT, 1'b1, reset value of the internal leading-zero-suppression enable.

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
En  input  1  1 = scanning; 0 = all digits off, divider and index frozen
Disp_Data  input  24  six BCD digits; [3:0] = digit 0 (rightmost) … [23:20] = digit 5 (leftmost)
Load_Req  input  1  1-cycle strobe: capture Disp_Data into the pending buffer
Lz_En  input  1  leading-zero suppression enable, sampled every cycle
Number_Data  output  4  digit code for the currently selected digit, 0–10
rScan  output  6  active-low one-hot digit select; digit k active = bit k low
Load_Ack  output  1  1-cycle pulse when the pending buffer is copied into the active buffer
Frame_Done  output  1  1-cycle pulse on the 5→0 index wrap

Behaviour:
- Reset (RST=1 at a CLK edge):
  - div_cnt=0, idx=0, pend_valid=0.
  - active_buf=0, pend_buf=0.
  - rScan=6'b111111, Number_Data=4'd0, Load_Ack=0, Frame_Done=0.
  - Reset mid-frame discards any pending load; no Load_Ack is issued for it.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 while En=1.
  - tick = (div_cnt==SCAN_DIV-1) & En; div_cnt wraps to 0 on tick.
- Index: on tick, idx increments 0→1→…→5→0. wrap = tick & (idx==5).
- Load buffering:
  - Load_Req=1 sets pend_buf<=Disp_Data and pend_valid<=1.
  - A later Load_Req before apply overwrites pend_buf; last write wins, and only one Load_Ack is issued.
  - On wrap with pend_valid=1: active_buf<=pend_buf, pend_valid<=0, Load_Ack=1 in the following cycle.
  - Load_Req in the same cycle as wrap: the Disp_Data of that cycle goes straight to active_buf, pend_valid ends 0, and Load_Ack pulses.
- Outputs:
  - Registered, updated in the cycle after tick. One slot = exactly SCAN_DIV cycles of a stable rScan/Number_Data pair.
  - Next slot digit k = idx after increment. rScan <= ~(6'b1 << k).
  - Number_Data <= active_buf digit k. Codes 10–15 clamp to 4'd10 (DP-only pattern).
  - The first slot after reset is selected by the first tick: digit 1.
  - Frame_Done pulses 1 cycle, aligned with the output update of digit 0.
- Leading-zero suppression (Lz_En=1):
  - Digit k is blanked if every digit j with k<=j<=5 in active_buf equals 0, and k!=0.
  - A blanked slot drives rScan=6'b111111 for the whole slot; Number_Data still shows the code and is don't-care.
  - Digit 0 is never blanked, so a value of 000000 shows a single "0".
- En:
  - En=0 forces rScan=6'b111111 on the next cycle and freezes div_cnt and idx.
  - Load_Req is still accepted while En=0, but the apply waits for the next wrap.
  - When En returns to 1, the display resumes at the frozen idx. The first output update comes at the next tick.
- Decimal point: smg_encode_module inserts the DP when rScan==6'b111011, i.e. on digit 2. This block must present that exact vector for digit 2; no other DP control is provided.
- Latency: Load_Req to visible new data is at most 6*SCAN_DIV+2 cycles.

Test Plan:
- SCAN_DIV=4, RST for 2 cycles, En=1, Disp_Data=24'h000000, no load -> rScan sequence 111101,111011,110111,101111,011111,111110 (Lz_En=0). Each vector lasts 4 cycles. Frame_Done pulses with 111110.
- Load_Req with Disp_Data=24'h123456 mid-frame -> no change until the wrap. Load_Ack 1 cycle after the wrap. Then rScan=111110 shows Number_Data=6, 111011 shows 4, 011111 shows 1.
- Lz_En=1, load 24'h000070 -> slots for digits 2–5 show rScan=111111. Digit 1 shows 7, digit 0 shows 0. Load 24'h000000 -> only digit 0 is driven, showing 0.
- Two Load_Req (24'h111111 then 24'h222222) in one frame, the second coinciding with the wrap -> active=222222 and exactly one Load_Ack.
- Load 24'hFA0009 -> digits 5 and 4 both output 4'd10, digit 0 outputs 9.
- En=0 for 10 cycles mid-slot, then RST mid-frame with a pending load -> rScan=111111 during En=0 with idx held. After RST all outputs are at reset values, with no Load_Ack and active_buf=0.
